// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I decode stage with valid/ready handshakes, load-use
// stall, flush and store-lane generation. Define ID_FORWARD_EN to enable EX/WB operand bypass.
module id_stage_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               inst_i,
  input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic                      ex_wr_en_i,
  input  logic                      ex_is_load_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     ex_rd_data_i,
  input  logic                      wb_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     wb_rd_data_i,
  input  logic                      flush_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_WIDTH-1:0]     op_data1_o,
  output logic [DATA_WIDTH-1:0]     op_data2_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH-1:0]     offset_addr_o,
  output logic [31:0]               inst_o,
  output logic [ADDR_WIDTH-1:0]     inst_addr_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH/8-1:0]   ram_wr_en_o,
  output logic [DATA_WIDTH-1:0]     ram_wr_data_o,
  output logic                      misalign_o
);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_SYS    = 7'b1110011
  } opcode_e;

  opcode_e                   opcode;
  logic [2:0]                funct3;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic signed [31:0]        imm_i32, imm_s32, imm_b32, imm_u32;
  logic [DATA_WIDTH-1:0]     imm_i, imm_s, imm_u, src1, src2, ea;
  logic                      use1, use2, haz1, haz2, stall, slot_free, accept, is_shift;

  assign opcode   = opcode_e'(inst_i[6:0]);
  assign funct3   = inst_i[14:12];
  assign rs1      = REG_ADDR_WIDTH'(inst_i[19:15]);
  assign rs2      = REG_ADDR_WIDTH'(inst_i[24:20]);
  assign rd       = REG_ADDR_WIDTH'(inst_i[11:7]);
  assign is_shift = (funct3[1:0] == 2'b01);

  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2;

  assign imm_i32 = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u32 = {inst_i[31:12], 12'b0};
  assign imm_i   = DATA_WIDTH'(imm_i32);
  assign imm_s   = DATA_WIDTH'(imm_s32);
  assign imm_u   = DATA_WIDTH'(imm_u32);

  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin use1 = 1'b1; use2 = 1'b1; end
      OP_I, OP_LOAD, OP_JALR:    use1 = 1'b1;
      default: ;
    endcase
  end

`ifdef ID_FORWARD_EN
  // Youngest writer wins; a load in EX has no data yet and is covered by the stall.
  assign src1 = (rs1 == '0) ? '0 :
                (ex_wr_en_i && !ex_is_load_i && ex_rd_addr_i == rs1) ? ex_rd_data_i :
                (wb_wr_en_i && wb_rd_addr_i == rs1) ? wb_rd_data_i : rs1_data_i;
  assign src2 = (rs2 == '0) ? '0 :
                (ex_wr_en_i && !ex_is_load_i && ex_rd_addr_i == rs2) ? ex_rd_data_i :
                (wb_wr_en_i && wb_rd_addr_i == rs2) ? wb_rd_data_i : rs2_data_i;
  assign haz1 = use1 && ex_wr_en_i && ex_is_load_i && ex_rd_addr_i != '0 && ex_rd_addr_i == rs1;
  assign haz2 = use2 && ex_wr_en_i && ex_is_load_i && ex_rd_addr_i != '0 && ex_rd_addr_i == rs2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_rd_data_i, wb_rd_data_i, ex_is_load_i};
  assign src1 = rs1_data_i;
  assign src2 = rs2_data_i;
  assign haz1 = use1 && ((ex_wr_en_i && ex_rd_addr_i != '0 && ex_rd_addr_i == rs1) ||
                         (wb_wr_en_i && wb_rd_addr_i != '0 && wb_rd_addr_i == rs1));
  assign haz2 = use2 && ((ex_wr_en_i && ex_rd_addr_i != '0 && ex_rd_addr_i == rs2) ||
                         (wb_wr_en_i && wb_rd_addr_i != '0 && wb_rd_addr_i == rs2));
`endif

  assign stall      = haz1 || haz2;
  assign slot_free  = !out_valid_o || out_ready_i;
  assign in_ready_o = slot_free && !stall && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign ea         = src1 + ((opcode == OP_STORE) ? imm_s : imm_i);

  logic [DATA_WIDTH-1:0]     op1_d, op2_d, wdata_d;
  logic [REG_ADDR_WIDTH-1:0] rd_d;
  logic [ADDR_WIDTH-1:0]     off_d, raddr_d;
  logic [NB-1:0]             wen_d;
  logic                      mis_d;

  always_comb begin
    op1_d   = '0;
    op2_d   = '0;
    rd_d    = '0;
    off_d   = '0;
    raddr_d = '0;
    wen_d   = '0;
    wdata_d = '0;
    mis_d   = 1'b0;
    case (opcode)
      OP_R: begin
        op1_d = src1;
        op2_d = is_shift ? DATA_WIDTH'(src2[4:0]) : src2;
        rd_d  = rd;
      end
      OP_I: begin
        op1_d = src1;
        op2_d = is_shift ? DATA_WIDTH'(inst_i[24:20]) : imm_i;
        rd_d  = rd;
      end
      OP_LOAD: begin
        op1_d   = src1;
        op2_d   = imm_i;
        rd_d    = rd;
        raddr_d = ADDR_WIDTH'(ea);
      end
      OP_STORE: begin
        op1_d   = src1;
        op2_d   = src2;
        raddr_d = ADDR_WIDTH'(ea);
        case (funct3)
          3'b000: begin
            wen_d   = NB'(1) << ea[1:0];
            wdata_d = DATA_WIDTH'(src2[7:0]) << {ea[1:0], 3'b000};
          end
          3'b001: begin
            if (ea[0]) mis_d = 1'b1;
            else begin
              wen_d   = NB'(3) << {ea[1], 1'b0};
              wdata_d = DATA_WIDTH'(src2[15:0]) << {ea[1], 4'b0000};
            end
          end
          3'b010: begin
            if (ea[1:0] != 2'b00) mis_d = 1'b1;
            else begin
              wen_d   = '1;
              wdata_d = src2;
            end
          end
          default: ;
        endcase
      end
      OP_BRANCH: begin
        op1_d = src1;
        op2_d = src2;
        off_d = ADDR_WIDTH'(imm_b32);
      end
      OP_LUI: begin
        op2_d = imm_u;
        rd_d  = rd;
      end
      OP_AUIPC: begin
        op1_d = DATA_WIDTH'(inst_addr_i);
        op2_d = imm_u;
        rd_d  = rd;
      end
      OP_JAL: begin
        op1_d = DATA_WIDTH'(inst_addr_i);
        op2_d = DATA_WIDTH'(4);
        rd_d  = rd;
      end
      OP_JALR: begin
        op1_d = src1;
        op2_d = imm_i;
        rd_d  = rd;
      end
      default: ;
    endcase
  end

  logic                      valid_q, mis_q;
  logic [DATA_WIDTH-1:0]     op1_q, op2_q, wdata_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [ADDR_WIDTH-1:0]     off_q, raddr_q, pc_q;
  logic [31:0]               inst_q;
  logic [NB-1:0]             wen_q;

  // Payload only moves on accept, so it is frozen under back-pressure and across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      off_q   <= '0;
      inst_q  <= '0;
      pc_q    <= '0;
      raddr_q <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (slot_free) begin
      valid_q <= accept;
      if (accept) begin
        op1_q   <= op1_d;
        op2_q   <= op2_d;
        rd_q    <= rd_d;
        off_q   <= off_d;
        inst_q  <= inst_i;
        pc_q    <= inst_addr_i;
        raddr_q <= raddr_d;
        wen_q   <= wen_d;
        wdata_q <= wdata_d;
        mis_q   <= mis_d;
      end
    end
  end

  assign out_valid_o   = valid_q;
  assign op_data1_o    = op1_q;
  assign op_data2_o    = op2_q;
  assign rd_addr_o     = rd_q;
  assign offset_addr_o = off_q;
  assign inst_o        = inst_q;
  assign inst_addr_o   = pc_q;
  assign ram_addr_o    = raddr_q;
  assign ram_wr_en_o   = wen_q;
  assign ram_wr_data_o = wdata_q;
  assign misalign_o    = mis_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic against a
// behavioural decode/handshake model; honours ID_FORWARD_EN like the design.
module tb_id_stage_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i, in_ready_o, ex_wr_en_i, ex_is_load_i, wb_wr_en_i, flush_i;
  logic        out_valid_o, out_ready_i, misalign_o;
  logic [31:0] inst_i, inst_addr_i, rs1_data_i, rs2_data_i, ex_rd_data_i, wb_rd_data_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o, ex_rd_addr_i, wb_rd_addr_i, rd_addr_o;
  logic [31:0] op_data1_o, op_data2_o, offset_addr_o, inst_o, inst_addr_o;
  logic [31:0] ram_addr_o, ram_wr_data_o;
  logic [3:0]  ram_wr_en_o;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .ex_wr_en_i(ex_wr_en_i),
    .ex_is_load_i(ex_is_load_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i),
    .wb_wr_en_i(wb_wr_en_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .op_data1_o(op_data1_o), .op_data2_o(op_data2_o), .rd_addr_o(rd_addr_o),
    .offset_addr_o(offset_addr_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .ram_addr_o(ram_addr_o), .ram_wr_en_o(ram_wr_en_o), .ram_wr_data_o(ram_wr_data_o),
    .misalign_o(misalign_o)
  );

  typedef struct {
    logic [31:0] op1, op2, off, inst, pc, raddr, wdata;
    logic [4:0]  rd;
    logic [3:0]  wen;
    logic        mis;
  } exp_t;

  exp_t mo;
  logic mv = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic signed [31:0] t;
    t = v << (32 - bits);
    return t >>> (32 - bits);
  endfunction

  function automatic void uses(input logic [31:0] i, output bit u1, output bit u2);
    u1 = 0;
    u2 = 0;
    case (i[6:0])
      7'h33, 7'h23, 7'h63: begin u1 = 1; u2 = 1; end
      7'h13, 7'h03, 7'h67: u1 = 1;
      default: ;
    endcase
  endfunction

  function automatic bit hazard(input logic [4:0] idx);
`ifdef ID_FORWARD_EN
    return ex_wr_en_i && ex_is_load_i && ex_rd_addr_i != 0 && ex_rd_addr_i == idx;
`else
    return (ex_wr_en_i && ex_rd_addr_i != 0 && ex_rd_addr_i == idx) ||
           (wb_wr_en_i && wb_rd_addr_i != 0 && wb_rd_addr_i == idx);
`endif
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
`ifdef ID_FORWARD_EN
    if (idx == 0) return 32'h0;
    if (ex_wr_en_i && !ex_is_load_i && ex_rd_addr_i == idx) return ex_rd_data_i;
    if (wb_wr_en_i && wb_rd_addr_i == idx) return wb_rd_data_i;
`endif
    return rf;
  endfunction

  function automatic exp_t decode(input logic [31:0] i, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] immi, ea;
    int sz, lo;
    logic [2:0] f3;
    e = '{default: '0};
    e.inst = i;
    e.pc = pc;
    f3 = i[14:12];
    immi = sx(i >> 20, 12);
    case (i[6:0])
      7'h33: begin e.op1 = a; e.op2 = (f3 == 1 || f3 == 5) ? (b & 32'h1f) : b; e.rd = i[11:7]; end
      7'h13: begin e.op1 = a; e.op2 = (f3 == 1 || f3 == 5) ? {27'b0, i[24:20]} : immi; e.rd = i[11:7]; end
      7'h03: begin e.op1 = a; e.op2 = immi; e.rd = i[11:7]; e.raddr = a + immi; end
      7'h23: begin
        ea = a + sx({20'b0, i[31:25], i[11:7]}, 12);
        e.op1 = a;
        e.op2 = b;
        e.raddr = ea;
        if (f3 <= 2) begin
          sz = 1 << f3;
          lo = int'(ea[1:0]);
          if (lo % sz != 0) e.mis = 1'b1;
          else
            for (int k = 0; k < 4; k++)
              if (k >= lo && k < lo + sz) begin
                e.wen[k] = 1'b1;
                e.wdata[8*k +: 8] = b[8*(k-lo) +: 8];
              end
        end
      end
      7'h63: begin
        e.op1 = a;
        e.op2 = b;
        e.off = sx({19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
      end
      7'h37: begin e.op2 = i & 32'hFFFFF000; e.rd = i[11:7]; end
      7'h17: begin e.op1 = pc; e.op2 = i & 32'hFFFFF000; e.rd = i[11:7]; end
      7'h6F: begin e.op1 = pc; e.op2 = 32'd4; e.rd = i[11:7]; end
      7'h67: begin e.op1 = a; e.op2 = immi; e.rd = i[11:7]; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    logic [6:0] op;
    i = $urandom;
    case ($urandom_range(0, 10))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h37;  6: op = 7'h17;  7: op = 7'h6F;
      8: op = 7'h67;  9: op = 7'h73;  default: op = 7'h0B;
    endcase
    i[6:0]   = op;
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    if (op == 7'h23) i[14:12] = 3'($urandom_range(0, 2));
    return i;
  endfunction

  task automatic compare();
    chk("out_valid", out_valid_o, mv);
    if (mv) begin
      chk("op_data1", op_data1_o, mo.op1);
      chk("op_data2", op_data2_o, mo.op2);
      chk("rd_addr", rd_addr_o, mo.rd);
      chk("offset_addr", offset_addr_o, mo.off);
      chk("inst", inst_o, mo.inst);
      chk("inst_addr", inst_addr_o, mo.pc);
      chk("ram_addr", ram_addr_o, mo.raddr);
      chk("ram_wr_en", ram_wr_en_o, mo.wen);
      chk("ram_wr_data", ram_wr_data_o, mo.wdata);
      chk("misalign", misalign_o, mo.mis);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid_o, 0);
    chk({tag, "_op1"}, op_data1_o, 0);
    chk({tag, "_op2"}, op_data2_o, 0);
    chk({tag, "_rd"}, rd_addr_o, 0);
    chk({tag, "_off"}, offset_addr_o, 0);
    chk({tag, "_inst"}, inst_o, 0);
    chk({tag, "_pc"}, inst_addr_o, 0);
    chk({tag, "_raddr"}, ram_addr_o, 0);
    chk({tag, "_wen"}, ram_wr_en_o, 0);
    chk({tag, "_wdata"}, ram_wr_data_o, 0);
    chk({tag, "_mis"}, misalign_o, 0);
  endtask

  // Inputs are already driven; check ready, step the model at the edge, compare at negedge.
  task automatic cycle();
    bit u1, u2, st, rdy;
    #1;
    uses(inst_i, u1, u2);
    st  = (u1 && hazard(inst_i[19:15])) || (u2 && hazard(inst_i[24:20]));
    rdy = (!mv || out_ready_i) && !st && !flush_i;
    chk("in_ready", in_ready_o, rdy);
    chk("rs1_addr", rs1_addr_o, inst_i[19:15]);
    chk("rs2_addr", rs2_addr_o, inst_i[24:20]);
    @(posedge clk);
    if (flush_i) mv = 1'b0;
    else if (!mv || out_ready_i) begin
      if (in_valid_i && !st) begin
        mo = decode(inst_i, inst_addr_i, operand(inst_i[19:15], rs1_data_i),
                    operand(inst_i[24:20], rs2_data_i));
        mv = 1'b1;
      end else mv = 1'b0;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    in_valid_i = 0; flush_i = 0; out_ready_i = 1; inst_i = 0; inst_addr_i = 0;
    rs1_data_i = 0; rs2_data_i = 0;
    ex_wr_en_i = 0; ex_is_load_i = 0; ex_rd_addr_i = 0; ex_rd_data_i = 0;
    wb_wr_en_i = 0; wb_rd_addr_i = 0; wb_rd_data_i = 0;
  endtask

  task automatic rand_inputs();
    in_valid_i   = ($urandom_range(0, 9) < 8);
    out_ready_i  = ($urandom_range(0, 9) < 7);
    flush_i      = ($urandom_range(0, 19) == 0);
    inst_i       = rand_inst();
    inst_addr_i  = $urandom & 32'hFFFF_FFFC;
    rs1_data_i   = $urandom;
    rs2_data_i   = $urandom;
    ex_wr_en_i   = $urandom_range(0, 1);
    ex_is_load_i = ($urandom_range(0, 9) < 3);
    ex_rd_addr_i = 5'($urandom_range(0, 3));
    ex_rd_data_i = $urandom;
    wb_wr_en_i   = $urandom_range(0, 1);
    wb_rd_addr_i = 5'($urandom_range(0, 3));
    wb_rd_data_i = $urandom;
  endtask

  initial begin
    idle();
    #2;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", in_ready_o, 1);

    // ADDI x1,x0,5 followed by ADD x2,x1,x1 with x1 still being written
    @(negedge clk);
    in_valid_i = 1; inst_i = 32'h00500093; inst_addr_i = 32'h1000;
    cycle();
    chk("addi_op2", op_data2_o, 32'd5);
    inst_i = 32'h00108133; inst_addr_i = 32'h1004;
    ex_wr_en_i = 1; ex_rd_addr_i = 1; ex_rd_data_i = 5;
`ifdef ID_FORWARD_EN
    cycle();
    chk("fwd_add_op1", op_data1_o, 32'd5);
    chk("fwd_add_op2", op_data2_o, 32'd5);
`else
    #1 chk("nofwd_ex_stall", in_ready_o, 0);
    cycle();
    ex_wr_en_i = 0; wb_wr_en_i = 1; wb_rd_addr_i = 1; wb_rd_data_i = 5;
    #1 chk("nofwd_wb_stall", in_ready_o, 0);
    cycle();
    wb_wr_en_i = 0; rs1_data_i = 5; rs2_data_i = 5;
    cycle();
    chk("nofwd_add_op1", op_data1_o, 32'd5);
    chk("nofwd_add_op2", op_data2_o, 32'd5);
`endif

    // Load-use: LW x3 in EX, ADD x4,x3,x0 must wait
    idle();
    in_valid_i = 1; inst_i = 32'h00018233; inst_addr_i = 32'h1008;
    ex_wr_en_i = 1; ex_is_load_i = 1; ex_rd_addr_i = 3;
    #1 chk("loaduse_ready", in_ready_o, 0);
    cycle();
    chk("loaduse_bubble", out_valid_o, 0);
    cycle();
    ex_wr_en_i = 0; ex_is_load_i = 0; rs1_data_i = 32'h77;
    cycle();
    chk("loaduse_issue", out_valid_o, 1);
    chk("loaduse_op1", op_data1_o, 32'h77);

    // SB x2,3(x1) with x1=0x100, x2=0xAB
    idle();
    in_valid_i = 1; inst_i = 32'h002081A3; rs1_data_i = 32'h100; rs2_data_i = 32'hAB;
    cycle();
    chk("sb_wr_en", ram_wr_en_o, 4'b1000);
    chk("sb_wr_data", ram_wr_data_o, 32'hAB000000);
    chk("sb_misalign", misalign_o, 0);
    chk("sb_addr", ram_addr_o, 32'h103);

    // SW x2,2(x1) -> misaligned
    inst_i = 32'h0020A123;
    cycle();
    chk("sw_wr_en", ram_wr_en_o, 0);
    chk("sw_misalign", misalign_o, 1);

    // Back-pressure for three cycles, then release
    out_ready_i = 0; inst_i = 32'h00500093;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("bp_hold_mis", misalign_o, 1);
      chk("bp_hold_addr", ram_addr_o, 32'h102);
    end
    out_ready_i = 1;
    cycle();
    chk("bp_release_inst", inst_o, 32'h00500093);

    // Flush while holding a valid output with a pending input
    out_ready_i = 0; flush_i = 1; inst_i = 32'h00108133;
    #1 chk("flush_ready", in_ready_o, 0);
    cycle();
    chk("flush_valid", out_valid_o, 0);
    idle();
    cycle();

    // Randomized traffic with one asynchronous reset mid-stream
    for (int n = 0; n < 1500; n++) begin
      rand_inputs();
      if (n == 700) begin
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        mv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rand_inputs();
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
